// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared dimension helpers for the convolution datapath
package conv_pkg;

   function automatic int padded_dim(input int img, input int pad);
      return img + 2 * pad;
   endfunction

   function automatic int coord_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/zero_padding_stream_if.sv
// rtl/zero_padding_stream_if.sv - input/output stream bundle; data_out_last present under ZERO_PADDING_STREAM_LAST_EN
interface zero_padding_stream_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  data_in_valid;
   logic                  data_in_ready;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  data_out_valid;
   logic                  data_out_ready;
`ifdef ZERO_PADDING_STREAM_LAST_EN
   logic                  data_out_last;
`endif

   modport slave (
      input  data_in,
      input  data_in_valid,
      output data_in_ready,
      output data_out,
      output data_out_valid,
      input  data_out_ready
`ifdef ZERO_PADDING_STREAM_LAST_EN
      ,
      output data_out_last
`endif
   );

   modport master (
      output data_in,
      output data_in_valid,
      input  data_in_ready,
      input  data_out,
      input  data_out_valid,
      output data_out_ready
`ifdef ZERO_PADDING_STREAM_LAST_EN
      ,
      input  data_out_last
`endif
   );
endinterface

// File: rtl/padding_coord_counter.sv
// rtl/padding_coord_counter.sv - nested channel/column/row counters over the padded frame
module padding_coord_counter
   import conv_pkg::*;
#(
   parameter int IMG_WIDTH      = 4,
   parameter int IMG_HEIGHT     = 3,
   parameter int PADDING_WIDTH  = 1,
   parameter int PADDING_HEIGHT = 1,
   parameter int CHANNELS       = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic advance,
   output logic interior,
   output logic frame_end
);
   localparam int PW = padded_dim(IMG_WIDTH, PADDING_WIDTH);
   localparam int PH = padded_dim(IMG_HEIGHT, PADDING_HEIGHT);
   localparam int CW = coord_width(CHANNELS);
   localparam int XW = coord_width(PW);
   localparam int YW = coord_width(PH);

   localparam logic [CW-1:0] C_MAX = CW'(CHANNELS - 1);
   localparam logic [XW-1:0] X_MAX = XW'(PW - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(PH - 1);
   localparam logic [XW-1:0] X_LO  = XW'(PADDING_WIDTH);
   localparam logic [XW-1:0] X_HI  = XW'(PADDING_WIDTH + IMG_WIDTH);
   localparam logic [YW-1:0] Y_LO  = YW'(PADDING_HEIGHT);
   localparam logic [YW-1:0] Y_HI  = YW'(PADDING_HEIGHT + IMG_HEIGHT);

   logic [CW-1:0] pc;
   logic [XW-1:0] px;
   logic [YW-1:0] py;

   assign interior  = (py >= Y_LO) && (py < Y_HI) && (px >= X_LO) && (px < X_HI);
   assign frame_end = (pc == C_MAX) && (px == X_MAX) && (py == Y_MAX);

   // Wrapping the last coordinate straight back to zero starts the next frame with no gap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= '0;
         px <= '0;
         py <= '0;
      end else if (advance) begin
         if (pc == C_MAX) begin
            pc <= '0;
            if (px == X_MAX) begin
               px <= '0;
               py <= (py == Y_MAX) ? '0 : py + 1'b1;
            end else begin
               px <= px + 1'b1;
            end
         end else begin
            pc <= pc + 1'b1;
         end
      end
   end
endmodule

// File: rtl/zero_padding_stream.sv
// rtl/zero_padding_stream.sv - border-inserting stream stage; optional data_out_last under ZERO_PADDING_STREAM_LAST_EN
module zero_padding_stream
   import conv_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    IMG_WIDTH      = 4,
   parameter int                    IMG_HEIGHT     = 3,
   parameter int                    PADDING_WIDTH  = 1,
   parameter int                    PADDING_HEIGHT = 1,
   parameter int                    CHANNELS       = 2,
   parameter logic [DATA_WIDTH-1:0] PAD_VALUE      = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   zero_padding_stream_if.slave  bus
);
   logic                  interior;
   logic                  frame_end;
   logic                  load_en;
   logic                  advance;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;

   assign load_en           = !out_valid || bus.data_out_ready;
   assign bus.data_in_ready = interior && load_en;
   // An interior slot without input is a bubble: the register loads invalid and coordinates hold.
   assign advance           = load_en && (!interior || bus.data_in_valid);

   padding_coord_counter #(
      .IMG_WIDTH      (IMG_WIDTH),
      .IMG_HEIGHT     (IMG_HEIGHT),
      .PADDING_WIDTH  (PADDING_WIDTH),
      .PADDING_HEIGHT (PADDING_HEIGHT),
      .CHANNELS       (CHANNELS)
   ) u_coord (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .interior  (interior),
      .frame_end (frame_end)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (load_en) begin
         out_data  <= interior ? bus.data_in : PAD_VALUE;
         out_valid <= advance;
      end
   end

   assign bus.data_out       = out_data;
   assign bus.data_out_valid = out_valid;

`ifdef ZERO_PADDING_STREAM_LAST_EN
   logic out_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_last <= 1'b0;
      end else if (load_en) begin
         out_last <= frame_end && advance;
      end
   end

   assign bus.data_out_last = out_last;
`endif
endmodule
